// File: rtl/table_stream_ctrl.sv
// table_stream_ctrl: reads n_tables precomputed-power tables in lockstep and streams
// consecutive chunks of n_words entries out through a 2-entry valid/ready buffer.
// chunk_base advances at each chunk end and wraps to 0 at the configured table depth.
module table_stream_ctrl #(
    parameter int unsigned n_tables = 3,
    parameter int unsigned dwidth   = 27,
    parameter int unsigned awidth   = 15,
    parameter int unsigned n_words  = 40,
    parameter int unsigned depth    = 2**awidth
) (
    input  logic                       clk,
    input  logic                       ctrl_reset,
    input  logic [dwidth-1:0]          tdatai,
    input  logic [awidth-1:0]          twraddr,
    input  logic [n_tables-1:0]        twren,
    input  logic [1:0]                 command,
    output logic [n_tables*dwidth-1:0] tdata,
    output logic                       tvalid,
    input  logic                       tready,
    output logic                       tlast,
    output logic [awidth-1:0]          chunk_base,
    output logic                       idle
);

    localparam int unsigned TW = n_tables * dwidth;
    localparam int unsigned SW = awidth + 1;

    localparam logic [SW-1:0]     NWordsExt = SW'(n_words);
    localparam logic [SW-1:0]     WrapLimit = SW'(depth - n_words);
    localparam logic [awidth-1:0] LastCount = awidth'(n_words - 1);

    localparam logic [1:0] CmdStart = 2'b01;
    localparam logic [1:0] CmdReset = 2'b10;
    localparam logic [1:0] CmdAbort = 2'b11;

    typedef enum logic [1:0] {StIdle, StStrm, StDrain} state_e;

    state_e            state_q, state_d;
    logic [awidth-1:0] count_q, count_d;
    logic [awidth-1:0] chunk_base_q, chunk_base_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [1:0]        occ_q, occ_d;
    logic [TW-1:0]     fifo_data_q [2];
    logic [TW-1:0]     fifo_data_d [2];
    logic              fifo_last_q [2];
    logic              fifo_last_d [2];

    logic              issue;
    logic              issue_ok;
    logic              pop;
    logic              push;
    logic              abort;
    logic [awidth-1:0] rd_addr;
    logic [TW-1:0]     rd_data;
    logic [SW-1:0]     base_sum;
    logic [awidth-1:0] next_base;
    logic [1:0]        wr_idx;

    assign rd_addr = chunk_base_q + count_q;

    // Table RAMs: independent write port and 1-cycle registered read port.
    for (genvar i = 0; i < n_tables; i++) begin : g_table
        logic [dwidth-1:0] mem [depth];
        logic [dwidth-1:0] rd_q;

        // Host write port; a same-address read in this cycle still sees the old word.
        always_ff @(posedge clk) begin
            if (twren[i]) begin
                mem[twraddr] <= tdatai;
            end
        end

        // Read port, only clocked when a word is issued.
        always_ff @(posedge clk) begin
            if (issue) begin
                rd_q <= mem[rd_addr];
            end
        end

        assign rd_data[i*dwidth +: dwidth] = rd_q;
    end

    assign tvalid = (occ_q != 2'd0);
    assign pop    = tvalid & tready;
    assign abort  = (state_q != StIdle) && (command == CmdAbort);

    // Buffer slots already claimed (occupancy plus the read landing next cycle) must
    // stay below 2 after this cycle's pop; this keeps one word per cycle under tready=1.
    assign issue_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    // Chunk-end base computed one bit wider so the wrap compare cannot overflow.
    assign base_sum  = {1'b0, chunk_base_q} + NWordsExt;
    assign next_base = (base_sum > WrapLimit) ? '0 : base_sum[awidth-1:0];

    // Control FSM: command decode, read issue and chunk-base update.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        chunk_base_d    = chunk_base_q;
        issue           = 1'b0;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (command == CmdStart) begin
                    count_d = '0;
                    state_d = StStrm;
                end else if (command == CmdReset) begin
                    chunk_base_d = '0;
                end
            end
            StStrm: begin
                if (abort) begin
                    state_d      = StIdle;
                    chunk_base_d = next_base;
                end else if (issue_ok) begin
                    issue   = 1'b1;
                    count_d = count_q + awidth'(1);
                    if (count_q == LastCount) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (abort || (tlast && tready)) begin
                    state_d      = StIdle;
                    chunk_base_d = next_base;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        inflight_d      = issue;
        inflight_last_d = issue && (count_q == LastCount);
    end

    assign push   = inflight_q & ~abort;
    assign wr_idx = occ_q - {1'b0, pop};

    // Output FIFO: slot 0 is the head; pop shifts slot 1 down, push fills the first free slot.
    always_comb begin
        occ_d          = occ_q;
        fifo_data_d[0] = fifo_data_q[0];
        fifo_data_d[1] = fifo_data_q[1];
        fifo_last_d[0] = fifo_last_q[0];
        fifo_last_d[1] = fifo_last_q[1];

        if (abort) begin
            occ_d = 2'd0;
        end else begin
            if (pop) begin
                fifo_data_d[0] = fifo_data_q[1];
                fifo_last_d[0] = fifo_last_q[1];
            end
            if (push) begin
                if (wr_idx == 2'd0) begin
                    fifo_data_d[0] = rd_data;
                    fifo_last_d[0] = inflight_last_q;
                end else begin
                    fifo_data_d[1] = rd_data;
                    fifo_last_d[1] = inflight_last_q;
                end
            end
            occ_d = occ_q - {1'b0, pop} + {1'b0, push};
        end
    end

    // Control and buffer state registers.
    always_ff @(posedge clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q         <= StIdle;
            count_q         <= '0;
            chunk_base_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            chunk_base_q    <= chunk_base_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            fifo_data_q[0]  <= fifo_data_d[0];
            fifo_data_q[1]  <= fifo_data_d[1];
            fifo_last_q[0]  <= fifo_last_d[0];
            fifo_last_q[1]  <= fifo_last_d[1];
        end
    end

    assign tdata      = fifo_data_q[0];
    assign tlast      = tvalid & fifo_last_q[0];
    assign chunk_base = chunk_base_q;
    assign idle       = (state_q == StIdle);

endmodule

// File: tb/tb_table_stream_ctrl.sv
// Directed bench for table_stream_ctrl (3 tables, depth 128, 40-word chunks).
module tb_table_stream_ctrl;

    localparam int NT  = 3;
    localparam int DW  = 27;
    localparam int AW  = 7;
    localparam int NW  = 40;
    localparam int DEP = 128;
    localparam int TW  = NT * DW;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] RST   = 2'b10;
    localparam logic [1:0] ABORT = 2'b11;

    logic          clk = 1'b0;
    logic          ctrl_reset;
    logic [DW-1:0] tdatai;
    logic [AW-1:0] twraddr;
    logic [NT-1:0] twren;
    logic [1:0]    command;
    logic [TW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [AW-1:0] chunk_base;
    logic          idle;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model [NT][DEP];

    // Per-cycle side script applied while a chunk streams.
    logic [1:0]    cmd_at    [NW+2];
    int            wr_tbl_at [NW+2];
    int            wr_adr_at [NW+2];
    logic [DW-1:0] wr_val_at [NW+2];
    bit            wr_now_at [NW+2];

    always #5 clk = ~clk;

    table_stream_ctrl #(
        .n_tables (NT),
        .dwidth   (DW),
        .awidth   (AW),
        .n_words  (NW),
        .depth    (DEP)
    ) dut (
        .clk        (clk),
        .ctrl_reset (ctrl_reset),
        .tdatai     (tdatai),
        .twraddr    (twraddr),
        .twren      (twren),
        .command    (command),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (tready),
        .tlast      (tlast),
        .chunk_base (chunk_base),
        .idle       (idle)
    );

    function automatic logic [TW-1:0] exp_word(input int a);
        logic [TW-1:0] w;
        for (int t = 0; t < NT; t++) w[t*DW +: DW] = model[t][a];
        return w;
    endfunction

    task automatic clear_script();
        for (int c = 0; c < NW + 2; c++) begin
            cmd_at[c]    = NOP;
            wr_tbl_at[c] = -1;
            wr_adr_at[c] = 0;
            wr_val_at[c] = '0;
            wr_now_at[c] = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [1:0] c);
        command = c;
        @(posedge clk);
        #1;
        command = NOP;
    endtask

    task automatic fill_tables();
        for (int t = 0; t < NT; t++) begin
            for (int a = 0; a < DEP; a++) begin
                twren       = NT'(1 << t);
                twraddr     = AW'(a);
                tdatai      = DW'((t << 16) | a);
                model[t][a] = DW'((t << 16) | a);
                @(posedge clk);
                #1;
            end
        end
        twren = '0;
    endtask

    // START, then stream one chunk with tready high, applying the side script.
    task automatic run_chunk(input int base, input int nxt);
        send_cmd(START);
        n_tests++;
        if (idle !== 1'b0) begin
            n_fail++;
            $display("FAIL start_idle base=%0d got %b want 0", base, idle);
        end
        for (int c = 0; c < NW + 2; c++) begin
            command = cmd_at[c];
            if (wr_tbl_at[c] >= 0) begin
                twren   = NT'(1 << wr_tbl_at[c]);
                twraddr = AW'(wr_adr_at[c]);
                tdatai  = wr_val_at[c];
                if (wr_now_at[c]) model[wr_tbl_at[c]][wr_adr_at[c]] = wr_val_at[c];
            end else begin
                twren = '0;
            end
            @(negedge clk);
            n_tests++;
            if (tvalid !== (c >= 2)) begin
                n_fail++;
                $display("FAIL stream_valid base=%0d c=%0d got %b want %b", base, c, tvalid,
                         (c >= 2));
            end
            if (c >= 2) begin
                n_tests++;
                if (tdata !== exp_word(base + c - 2) || tlast !== (c == NW + 1)) begin
                    n_fail++;
                    $display("FAIL stream_word base=%0d c=%0d got %h/%b want %h/%b", base, c,
                             tdata, tlast, exp_word(base + c - 2), (c == NW + 1));
                end
            end
            n_tests++;
            if (chunk_base !== AW'(base)) begin
                n_fail++;
                $display("FAIL stream_base c=%0d got %0d want %0d", c, chunk_base, base);
            end
            @(posedge clk);
            #1;
        end
        command = NOP;
        twren   = '0;
        n_tests++;
        if (idle !== 1'b1 || tvalid !== 1'b0 || chunk_base !== AW'(nxt)) begin
            n_fail++;
            $display("FAIL chunk_end got idle=%b tvalid=%b base=%0d want 1 0 %0d", idle, tvalid,
                     chunk_base, nxt);
        end
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        command    = NOP;
        twren      = '0;
        twraddr    = '0;
        tdatai     = '0;
        tready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b want 0", tvalid); end
        n_tests++;
        if (tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b want 0", tlast); end
        n_tests++;
        if (tdata !== '0) begin n_fail++; $display("FAIL rst_tdata got %h want 0", tdata); end
        n_tests++;
        if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b want 1", idle); end
        n_tests++;
        if (chunk_base !== '0) begin
            n_fail++;
            $display("FAIL rst_base got %0d want 0", chunk_base);
        end
        ctrl_reset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (idle !== 1'b1 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst got idle=%b tvalid=%b want 1 0", idle, tvalid);
        end
    endtask

    task automatic test_stream_full();
        clear_script();
        run_chunk(0, 40);
    endtask

    task automatic test_abort();
        send_cmd(RST);
        n_tests++;
        if (chunk_base !== '0) begin
            n_fail++;
            $display("FAIL reset_cmd_base got %0d want 0", chunk_base);
        end
        send_cmd(START);
        // The 7th transfer (word 6) happens at c=8, on the ABORT edge.
        for (int c = 0; c <= 8; c++) begin
            command = (c == 8) ? ABORT : NOP;
            @(negedge clk);
            n_tests++;
            if (tvalid !== (c >= 2) || (c >= 2 && tdata !== exp_word(c - 2))) begin
                n_fail++;
                $display("FAIL abort_pre c=%0d got %b/%h want %b/%h", c, tvalid, tdata,
                         (c >= 2), exp_word(c - 2));
            end
            @(posedge clk);
            #1;
        end
        command = NOP;
        n_tests++;
        if (tvalid !== 1'b0 || idle !== 1'b1 || chunk_base !== AW'(40) || tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after got v=%b idle=%b base=%0d want 0 1 40", tvalid, idle,
                     chunk_base);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet c=%0d got %b want 0", c, tvalid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        clear_script();
        cmd_at[NW + 1] = START;
        run_chunk(40, 80);
        clear_script();
        @(posedge clk);
        #1;
        n_tests++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL start_at_tlast got idle=%b want 1", idle);
        end
        run_chunk(80, 0);
    endtask

    task automatic test_backpressure();
        int            n;
        bit            done;
        logic          prev_stall;
        logic          prev_last;
        logic [TW-1:0] prev_data;
        n          = 0;
        done       = 1'b0;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        prev_data  = '0;
        tready     = 1'b0;
        send_cmd(START);
        for (int c = 0; c < 600 && !done; c++) begin
            tready = (c < 6) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                n_tests++;
                if (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last) begin
                    n_fail++;
                    $display("FAIL bp_stable c=%0d got %b/%h/%b want 1/%h/%b", c, tvalid, tdata,
                             tlast, prev_data, prev_last);
                end
            end
            if (tvalid === 1'b1 && tready) begin
                n_tests++;
                if (tdata !== exp_word(n) || tlast !== (n == NW - 1)) begin
                    n_fail++;
                    $display("FAIL bp_word n=%0d got %h/%b want %h/%b", n, tdata, tlast,
                             exp_word(n), (n == NW - 1));
                end
                n++;
                if (n == NW) done = 1'b1;
            end
            prev_stall = tvalid & ~tready;
            prev_data  = tdata;
            prev_last  = tlast;
            @(posedge clk);
            #1;
        end
        tready = 1'b1;
        n_tests++;
        if (n != NW) begin n_fail++; $display("FAIL bp_count got %0d want %0d", n, NW); end
        n_tests++;
        if (idle !== 1'b1 || chunk_base !== AW'(40)) begin
            n_fail++;
            $display("FAIL bp_end got idle=%b base=%0d want 1 40", idle, chunk_base);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_extra c=%0d got %b want 0", c, tvalid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // START/RESET mid-stream are ignored; a write racing its own read yields old data.
    task automatic test_strm_cmds_and_writes();
        clear_script();
        cmd_at[3]    = START;
        cmd_at[4]    = RST;
        wr_tbl_at[5] = 1;
        wr_adr_at[5] = 45;
        wr_val_at[5] = 27'h5A5_0045;
        wr_tbl_at[6] = 2;
        wr_adr_at[6] = 60;
        wr_val_at[6] = 27'h3C3_0060;
        wr_now_at[6] = 1'b1;
        run_chunk(40, 80);
        model[1][45] = 27'h5A5_0045;
    endtask

    task automatic test_idle_cmds();
        send_cmd(ABORT);
        n_tests++;
        if (idle !== 1'b1 || tvalid !== 1'b0 || chunk_base !== AW'(80)) begin
            n_fail++;
            $display("FAIL idle_abort got idle=%b v=%b base=%0d want 1 0 80", idle, tvalid,
                     chunk_base);
        end
        send_cmd(NOP);
        n_tests++;
        if (idle !== 1'b1 || chunk_base !== AW'(80)) begin
            n_fail++;
            $display("FAIL idle_nop got idle=%b base=%0d want 1 80", idle, chunk_base);
        end
        send_cmd(RST);
        n_tests++;
        if (chunk_base !== '0) begin
            n_fail++;
            $display("FAIL idle_reset got %0d want 0", chunk_base);
        end
    endtask

    task automatic test_new_data();
        clear_script();
        run_chunk(0, 40);
        run_chunk(40, 80);
    endtask

    task automatic test_async_reset();
        send_cmd(START);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_tests++;
        if (tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre got tvalid=%b want 1", tvalid);
        end
        #2;
        ctrl_reset = 1'b1;
        #1;
        n_tests++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0 || idle !== 1'b1 ||
            chunk_base !== '0) begin
            n_fail++;
            $display("FAIL arst_outputs got v=%b l=%b d=%h idle=%b base=%0d want 0 0 0 1 0",
                     tvalid, tlast, tdata, idle, chunk_base);
        end
        @(posedge clk);
        #2;
        ctrl_reset = 1'b0;
        clear_script();
        run_chunk(0, 40);
    endtask

    initial begin
        test_reset();
        fill_tables();
        test_stream_full();
        test_abort();
        test_back_to_back();
        test_backpressure();
        test_strm_cmds_and_writes();
        test_idle_cmds();
        test_new_data();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/table_stream_ctrl.md
# table_stream_ctrl

Parametrised successor to the fixed three-table read streamer: owns `n_tables` precomputed-power tables of `dwidth`-bit words and streams consecutive chunks of `n_words` entries from all tables in lockstep to the multiexp datapath. Adds a valid/ready output handshake with full-throughput backpressure through a 2-entry output buffer. Adds chunk-base wrap-around at a configurable table depth, and a drain state so `idle` means no data is left in flight. Sits between the host dispatch write interface and the exponentiation units.

## Interface
- `n_tables`, 3: number of tables streamed in parallel.
- `dwidth`, 27: table word width.
- `awidth`, 15: table address width.
- `n_words`, 40: words per chunk; requires 1 ≤ `n_words` ≤ `depth`.
- `depth`, 2**`awidth`: entries per table.

- `clk`  in  1: single clock, all logic posedge.
- `ctrl_reset`  in  1: reset, asynchronous, active-high.
- `tdatai`  in  `dwidth`: write data shared by all tables.
- `twraddr`  in  `awidth`: write address.
- `twren`  in  `n_tables`: per-table write enable.
- `command`  in  2: 00 NOP, 01 START, 10 RESET, 11 ABORT; sampled every edge.
- `tdata`  out  `n_tables*dwidth`: table i occupies bits [i*dwidth +: dwidth].
- `tvalid`  out  1: `tdata`/`tlast` valid.
- `tready`  in  1: consumer accepts; transfer = `tvalid & tready`.
- `tlast`  out  1: current word is chunk word `n_words-1`.
- `chunk_base`  out  `awidth`: base address of the current/next chunk.
- `idle`  out  1: state IDLE.

## Operation
- Tables: one simple dual-port RAM per table, 1-cycle registered read; reads and writes are independent. Same-address read/write in the same cycle returns old data.
- States: IDLE, STRM, DRAIN.
- IDLE:
  - START → `count`=0, go to STRM.
  - RESET → `chunk_base`=0.
  - ABORT and NOP are ignored.
- STRM:
  - Issue a read at `chunk_base + count` when issue is allowed; then `count++`.
  - Issuing word `n_words-1` → DRAIN.
  - START and RESET are ignored.
- DRAIN:
  - No new reads.
  - → IDLE on the edge where the `tlast` word transfers, or with no handshake if the chunk was aborted.
- Issue allowed: `occ + inflight - pop < 2`.
  - `occ` = buffer occupancy, 0..2.
  - `inflight` = read issued last cycle, 0/1.
  - `pop` = transfer this cycle.
  - This rule sustains one word per cycle while `tready` is held high.
- Output buffer: 2-entry FIFO of {`tlast`, `tdata`}. RAM `q` is written the cycle after issue. `tvalid` = FIFO non-empty.
- ABORT in STRM or DRAIN:
  - Stop issuing.
  - Flush the FIFO and discard the in-flight read.
  - Go to IDLE on the same edge.
- Chunk end (completed or aborted): `chunk_base` ← `chunk_base + n_words`, or 0 if that sum is > `depth - n_words`. Computed at `awidth+1` bits, no overflow.
- Address computation `chunk_base + count` never exceeds `depth-1`, guaranteed by the wrap rule.

## Timing
- Reset values:
  - `tvalid`=0, `tlast`=0, `tdata`=0, `idle`=1, `chunk_base`=0.
  - State IDLE, FIFO empty, `inflight`=0.
  - Table contents undefined.
- START sampled at edge E:
  - `idle` falls after E.
  - First read issued in the cycle after E.
  - `tvalid` rises after E+2.
- With `tready` held high: `n_words` words on consecutive cycles; `tlast` on the final word; `idle` rises on the edge of the `tlast` transfer.
- `tready` low: the FIFO fills to 2 and issue stalls; no word is lost or duplicated. Data and `tlast` stay stable while `tvalid & ~tready`.
- ABORT sampled at edge A: `tvalid`=0, `idle`=1 and `chunk_base` advanced, all after A.
- START in the same cycle as a `tlast` transfer is ignored (state not yet IDLE). START is accepted the next cycle.
- `ctrl_reset` mid-stream: all outputs take reset values immediately.

## Test plan
- Write `tdata` = {table index, address} patterns, START, `tready`=1 → 40 words from addresses 0..39, `tvalid` high 40 consecutive cycles starting 2 cycles after START, `tlast` on word 39, `chunk_base`=40, `idle` back.
- Random `tready` (50%) over one chunk → exactly 40 transfers in address order; `tdata` stable while stalled; `tlast` only on the 40th transfer.
- ABORT after 7 transfers with `tready`=1 → `tvalid`=0 the next cycle, no further words, `chunk_base`=40; a following START streams addresses 40..79.
- `depth`=128, `n_words`=40: chunks start at 0, 40, 80, then 0 again (since 120 > 88); RESET in IDLE after chunk 1 → next chunk starts at 0.
- START/RESET during STRM are ignored; ABORT and NOP in IDLE have no effect; writes during streaming to the address being read return old data that cycle and new data afterwards.
- Assert `ctrl_reset` mid-chunk with `tvalid` high → outputs go to reset values asynchronously; after release, START streams from address 0.
